// File: rtl/plc_scrambler_par.sv
// Parallel PLC LFSR scrambler/descrambler: additive or self-synchronising, valid/ready.
// Optional bypass port when PLC_SCR_BYPASS_EN is defined.
module plc_scrambler_par #(
  parameter int                  REG_BITS  = 10,
  parameter int                  DATA_BITS = 8,
  parameter logic [REG_BITS-1:0] POLY      = 10'h204,
  parameter logic [REG_BITS-1:0] SEED      = 10'h3FF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 descramble,
  input  logic                 seed_ld,
  input  logic [REG_BITS-1:0]  seed_val,
`ifdef PLC_SCR_BYPASS_EN
  input  logic                 bypass,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data
);

  logic [REG_BITS-1:0]  state;
  logic [REG_BITS-1:0]  ld_state;
  logic [REG_BITS-1:0]  s_start;
  logic [REG_BITS-1:0]  s_end;
  logic [DATA_BITS-1:0] scr;
  logic [DATA_BITS-1:0] beat;
  logic                 accept;
  logic                 byp;

`ifdef PLC_SCR_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // a zero seed would lock the additive LFSR, so fall back to SEED
  assign ld_state = (seed_val == '0) ? SEED : seed_val;
  assign s_start  = seed_ld ? ld_state : state;

  always_comb begin
    logic [REG_BITS-1:0] s;
    logic                f;
    logic                ob;
    logic                b;
    s   = s_start;
    scr = '0;
    for (int k = 0; k < DATA_BITS; k++) begin
      f      = ^(s & POLY);
      ob     = in_data[k] ^ f;
      scr[k] = ob;
      b      = f;
      unique case (1'b1)
        ~mode:               b = f;
        mode & ~descramble:  b = ob;
        mode & descramble:   b = in_data[k];
      endcase
      s = {s[REG_BITS-2:0], b};
    end
    s_end = s;
  end

  assign beat = byp ? in_data : scr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= (accept && !byp) ? s_end : s_start;
      if (in_ready)
        out_valid <= in_valid;
      if (accept)
        out_data <= beat;
    end
  end

endmodule
